// File: rtl/key_debounce.sv
// Per-key debounce: stability counter FSM per channel, registered level plus press/release pulses.
// Optional KEY_DEBOUNCE_TOGGLE_EN turns each LED into a press-toggled register.
module key_debounce #(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned N_KEYS      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] led
);

   localparam int unsigned DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
   localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             press_d, press_q;
      logic             release_d, release_q;
      logic             level_d, level_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            level_q   <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            level_q   <= level_d;
         end
      end

      // Counter only advances while staying in a WAIT state; any other move clears it.
      always_comb begin
         state_d = state_q;
         cnt_d   = '0;
         case (state_q)
            StIdle: begin
               if (key_in[i]) state_d = StPressWait;
            end
            StPressWait: begin
               if (!key_in[i])            state_d = StIdle;
               else if (cnt_q == CNT_MAX) state_d = StPressed;
               else                       cnt_d   = cnt_q + 1'b1;
            end
            StPressed: begin
               if (!key_in[i]) state_d = StReleaseWait;
            end
            StReleaseWait: begin
               if (key_in[i])             state_d = StPressed;
               else if (cnt_q == CNT_MAX) state_d = StIdle;
               else                       cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = StIdle;
         endcase
      end

      always_comb begin
         press_d   = (state_q == StPressWait)   && (state_d == StPressed);
         release_d = (state_q == StReleaseWait) && (state_d == StIdle);
         level_d   = (state_d == StPressed)     || (state_d == StReleaseWait);
      end

      assign key_state[i]   = level_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;

`ifdef KEY_DEBOUNCE_TOGGLE_EN
      logic led_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)       led_q <= 1'b0;
         else if (press_q) led_q <= ~led_q;
      end

      assign led[i] = led_q;
`else
      assign led[i] = level_q;
`endif
   end

endmodule

// File: tb/tb_key_debounce.sv
// Table-driven bench for key_debounce with DEBOUNCE_CYCLES = 8, plus hand-written reset sequences.
module tb_key_debounce;

   localparam int N = 4;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
   localparam bit TOGGLE = 1'b1;
`else
   localparam bit TOGGLE = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] key_in;
   logic [N-1:0] key_state, key_press, key_release, led;

   key_debounce #(
      .CLK_FREQ_HZ(8000),
      .DEBOUNCE_MS(1),
      .N_KEYS     (N)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in),
      .key_state  (key_state),
      .key_press  (key_press),
      .key_release(key_release),
      .led        (led)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] key;
      logic [N-1:0] st;
      logic [N-1:0] pr;
      logic [N-1:0] rl;
   } vec_t;

   vec_t         vecs[$];
   int           checks   = 0;
   int           failures = 0;
   logic [N-1:0] led_m    = '0;

   task automatic add(input logic [N-1:0] k, input logic [N-1:0] s, input logic [N-1:0] p,
                      input logic [N-1:0] r, input int n);
      vec_t v;
      v.key = k; v.st = s; v.pr = p; v.rl = r;
      for (int j = 0; j < n; j++) vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [N-1:0] act,
                      input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%b want=%b t=%0t", name, idx, act, exp, $time);
      end
   endtask

   // led model: level copy, or toggle one cycle after each expected press pulse
   task automatic check_all(input int idx, input logic [N-1:0] s, input logic [N-1:0] p,
                            input logic [N-1:0] r);
      chk("key_state", idx, key_state, s);
      chk("key_press", idx, key_press, p);
      chk("key_release", idx, key_release, r);
      chk("led", idx, led, TOGGLE ? led_m : s);
      led_m = led_m ^ p;
   endtask

   task automatic step(input logic [N-1:0] k);
      key_in = k;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // all four keys: press after edge 9, then clean release
      add(4'hF, 4'h0, 4'h0, 4'h0, 8);
      add(4'hF, 4'hF, 4'hF, 4'h0, 1);
      add(4'hF, 4'hF, 4'h0, 4'h0, 3);
      add(4'h0, 4'hF, 4'h0, 4'h0, 8);
      add(4'h0, 4'h0, 4'h0, 4'hF, 1);
      add(4'h0, 4'h0, 4'h0, 4'h0, 2);
      // key0 clean press held 20 cycles, then release
      add(4'h1, 4'h0, 4'h0, 4'h0, 8);
      add(4'h1, 4'h1, 4'h1, 4'h0, 1);
      add(4'h1, 4'h1, 4'h0, 4'h0, 11);
      add(4'h0, 4'h1, 4'h0, 4'h0, 8);
      add(4'h0, 4'h0, 4'h0, 4'h1, 1);
      add(4'h0, 4'h0, 4'h0, 4'h0, 2);
      // key1 bounce 5/1/7/1, then held
      add(4'h2, 4'h0, 4'h0, 4'h0, 5);
      add(4'h0, 4'h0, 4'h0, 4'h0, 1);
      add(4'h2, 4'h0, 4'h0, 4'h0, 7);
      add(4'h0, 4'h0, 4'h0, 4'h0, 1);
      add(4'h2, 4'h0, 4'h0, 4'h0, 8);
      add(4'h2, 4'h2, 4'h2, 4'h0, 1);
      add(4'h2, 4'h2, 4'h0, 4'h0, 2);
      add(4'h0, 4'h2, 4'h0, 4'h0, 8);
      add(4'h0, 4'h0, 4'h0, 4'h2, 1);
      add(4'h0, 4'h0, 4'h0, 4'h0, 1);
      // key2 press, release bounce of 4 cycles, then clean release
      add(4'h4, 4'h0, 4'h0, 4'h0, 8);
      add(4'h4, 4'h4, 4'h4, 4'h0, 1);
      add(4'h4, 4'h4, 4'h0, 4'h0, 2);
      add(4'h0, 4'h4, 4'h0, 4'h0, 4);
      add(4'h4, 4'h4, 4'h0, 4'h0, 10);
      add(4'h0, 4'h4, 4'h0, 4'h0, 8);
      add(4'h0, 4'h0, 4'h0, 4'h4, 1);
      add(4'h0, 4'h0, 4'h0, 4'h0, 1);
      // counter at its last value but input drops on the deciding edge: no press
      add(4'h4, 4'h0, 4'h0, 4'h0, 8);
      add(4'h0, 4'h0, 4'h0, 4'h0, 2);
      // key3 three clean presses (led toggles in toggle build)
      for (int n = 0; n < 3; n++) begin
         add(4'h8, 4'h0, 4'h0, 4'h0, 8);
         add(4'h8, 4'h8, 4'h8, 4'h0, 1);
         add(4'h8, 4'h8, 4'h0, 4'h0, 2);
         add(4'h0, 4'h8, 4'h0, 4'h0, 8);
         add(4'h0, 4'h0, 4'h0, 4'h8, 1);
         add(4'h0, 4'h0, 4'h0, 4'h0, 1);
      end

      // reset held 3 cycles with every key pressed
      rst_n  = 1'b0;
      key_in = 4'hF;
      for (int c = 0; c < 3; c++) begin
         step(4'hF);
         check_all(-1, 4'h0, 4'h0, 4'h0);
      end
      #4 rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].key);
         check_all(i, vecs[i].st, vecs[i].pr, vecs[i].rl);
      end

      // reset mid-count: key1 settled pressed, key0 at count 6
      for (int c = 0; c < 8; c++) begin
         step(4'h2);
         check_all(1000 + c, 4'h0, 4'h0, 4'h0);
      end
      step(4'h2);
      check_all(1008, 4'h2, 4'h2, 4'h0);
      for (int c = 0; c < 7; c++) begin
         step(4'h3);
         check_all(1100 + c, 4'h2, 4'h0, 4'h0);
      end
      #2 rst_n = 1'b0;
      #1;
      led_m = '0;
      check_all(1200, 4'h0, 4'h0, 4'h0);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step(4'h3);
         check_all(1300 + c, 4'h0, 4'h0, 4'h0);
      end
      step(4'h3);
      check_all(1308, 4'h3, 4'h3, 4'h0);
      step(4'h3);
      check_all(1309, 4'h3, 4'h0, 4'h0);
      step(4'h3);
      check_all(1310, 4'h3, 4'h0, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
# key_debounce

Per-key debounce and event stage for the four board push-buttons. It sits directly downstream of the two-flop key synchroniser, which delivers active-high, clock-aligned "pressed" levels. It filters contact bounce with a per-key stability counter and emits a debounced level plus one-cycle press and release pulses. It also drives the board LEDs from the filtered result.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000, system clock frequency in Hz.
- `DEBOUNCE_MS`, default 20, required stable time in ms.
- `N_KEYS`, default 4, number of independent key channels.
- Derived: `DEBOUNCE_CYCLES = CLK_FREQ_HZ/1000*DEBOUNCE_MS`; must be ≥ 2.
- Derived: the counter is `$clog2(DEBOUNCE_CYCLES)` bits wide and counts 0 … `DEBOUNCE_CYCLES-1`.

Ports:
- `clk`, input, 1: system clock, 50 MHz on board.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `key_in`, input, `N_KEYS`: synchronised key levels; 1 = pressed.
- `key_state`, output, `N_KEYS`: debounced level; 1 = pressed.
- `key_press`, output, `N_KEYS`: one-cycle pulse on each debounced press.
- `key_release`, output, `N_KEYS`: one-cycle pulse on each debounced release.
- `led`, output, `N_KEYS`: LED drive; 1 = lit.

## Operation
- Each channel has an independent FSM and counter. Channels share no state.
- **Reset** (`rst_n`=0, asynchronous): every FSM goes to IDLE and every counter to 0.
  - Reset values of all outputs are 0: `key_state`, `key_press`, `key_release`, `led`.
- **IDLE** (stable released):
  - `key_in`=1 → PRESS_WAIT, counter cleared to 0.
- **PRESS_WAIT**:
  - `key_in`=0 → IDLE. Bounce is discarded; no event, counter cleared.
  - `key_in`=1 and counter = `DEBOUNCE_CYCLES-1` → PRESSED. On that edge, register `key_press`=1 and `key_state`=1.
  - Otherwise the counter increments.
- **PRESSED**:
  - `key_in`=0 → RELEASE_WAIT, counter cleared.
- **RELEASE_WAIT**:
  - `key_in`=1 → PRESSED. Bounce is discarded; no event.
  - `key_in`=0 and counter = `DEBOUNCE_CYCLES-1` → IDLE. On that edge, register `key_release`=1 and `key_state`=0.
  - Otherwise the counter increments.
- `key_press` and `key_release` are registered. Each is high for exactly one cycle, then returns to 0.
- Within one channel, `key_press` and `key_release` are never high in the same cycle.
- The counter never wraps. It is held or cleared outside the WAIT states.
- All outputs are registered. There is no combinational path from `key_in` to any output.

## Timing
- Let edge 1 be the first rising edge that samples `key_in`=1 in IDLE. If `key_in` stays 1, `key_press` and `key_state` rise after edge `DEBOUNCE_CYCLES+1`.
  - With default parameters: 1_000_001 edges, about 20 ms.
- Release latency is the same, counted from the first edge sampling 0 in PRESSED.
- A glitch of fewer than `DEBOUNCE_CYCLES` cycles on `key_in` produces no event and no change to `key_state`.
- A glitch restarts the stability window from 0 when the level next returns.
- Simultaneous presses on several keys each produce their own pulse, possibly in the same cycle.
- Reset asserted mid-count aborts the count. No event is emitted, even if the count was complete on the same edge.

## Configuration
- Macro: `KEY_DEBOUNCE_TOGGLE_EN`.
- **Defined:** `led[i]` is a toggle register.
  - It inverts on every cycle where `key_press[i]`=1. Release has no effect.
  - Reset value is 0.
  - Toggle latency is one cycle after `key_press`.
- **Undefined:** `led[i]` equals `key_state[i]`, with no added latency.

## Test plan
Bench parameters: `CLK_FREQ_HZ`=8000, `DEBOUNCE_MS`=1, so `DEBOUNCE_CYCLES`=8.

1. **Reset values.** Hold `rst_n`=0 for 3 cycles with `key_in`=4'b1111 → all outputs stay 0. Release `rst_n` → `key_press[3:0]` rises after edge 9. All four pulses are one cycle wide.
2. **Clean press and release.**
   - `key_in[0]`=1 held for 20 cycles → `key_press[0]`=1 for exactly one cycle, after edge 9.
   - `key_state[0]`=1 from then on.
   - Then `key_in[0]`=0 → `key_release[0]` pulses after 9 edges, and `key_state[0]` returns to 0.
3. **Bounce rejection.**
   - `key_in[1]` pattern: 1 for 5 cycles, 0 for 1, 1 for 7, 0 → no pulse, `key_state[1]` stays 0.
   - Then hold 1 → a single press pulse 9 edges after the last rising transition.
4. **Release bounce.** In PRESSED, drop `key_in[2]` to 0 for 4 cycles, then back to 1 → no `key_release[2]`, `key_state[2]` stays 1.
5. **Reset mid-count.** Pulse `rst_n` low asynchronously, mid-cycle, at count 6 of a press → outputs clear immediately and no `key_press` ever follows. After `rst_n`=1, a held key needs the full 9 edges again.
6. **Toggle, with `KEY_DEBOUNCE_TOGGLE_EN` defined.**
   - Three clean presses of key 3 → `led[3]` sequence 1, 0, 1, each change one cycle after `key_press[3]`.
   - Without the macro → `led` equals `key_state` every cycle.
